// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, instruction register and retire counter
module pc_fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pc_en,
    input  logic              i_branch,
    input  logic              i_jump,
    input  logic              i_ir_load,
    input  logic              i_addr_sel,
    input  logic [15:0]       i_mem_dout,
    input  logic [15:0]       i_jump_target,
    input  logic [15:0]       i_data_addr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [15:0]       o_pc_plus1,
    output logic [15:0]       o_instr,
    output logic [15:0]       o_disp_ext,
    output logic              o_halted,
    output logic              o_seq_err,
    output logic [CNT_W-1:0]  o_retired
);

    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_instr;
    logic              r_halted;
    logic              r_seq_err;
    logic [CNT_W-1:0]  r_retired;

    logic [15:0]       w_disp_ext;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_branch;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_halt_set;
    logic              w_retired_max;

    // Displacement is the signed low byte of the latched instruction.
    assign w_disp_ext    = {{8{r_instr[7]}}, r_instr[7:0]};
    // PC arithmetic wraps naturally at ADDR_W bits.
    assign w_pc_inc      = r_pc + ADDR_W'(1);
    assign w_pc_branch   = r_pc + w_disp_ext[ADDR_W-1:0];
    // Branch-to-self: a taken branch with zero displacement parks the PC.
    assign w_halt_set    = i_branch & ~i_jump & (r_instr[7:0] == 8'h00);
    assign w_retired_max = &r_retired;

    // Next-PC select: jump beats branch beats sequential increment.
    always_comb begin
        w_next_pc = w_pc_inc;
        if (i_jump) begin
            w_next_pc = i_jump_target[ADDR_W-1:0];
        end else if (i_branch) begin
            w_next_pc = w_pc_branch;
        end
    end

    // State update; reset discards every strobe sampled in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_instr   <= 16'h0000;
            r_halted  <= 1'b0;
            r_seq_err <= 1'b0;
            r_retired <= '0;
        end else begin
            if (i_pc_en) begin
                r_pc <= w_next_pc;
                if (w_halt_set) begin
                    r_halted <= 1'b1;
                end else if (w_next_pc != r_pc) begin
                    r_halted <= 1'b0;
                end
                if (i_branch && i_jump) begin
                    r_seq_err <= 1'b1;
                end
                if (!w_retired_max) begin
                    r_retired <= r_retired + CNT_W'(1);
                end
            end
            if (i_ir_load) begin
                r_instr <= i_mem_dout;
            end
        end
    end

    assign o_mem_addr = i_addr_sel ? r_pc : i_data_addr[ADDR_W-1:0];
    assign o_pc       = r_pc;
    assign o_pc_plus1 = 16'(w_pc_inc);
    assign o_instr    = r_instr;
    assign o_disp_ext = w_disp_ext;
    assign o_halted   = r_halted;
    assign o_seq_err  = r_seq_err;
    assign o_retired  = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit (16-bit and 8-bit builds)
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en, branch, jump, ir_load, addr_sel;
    logic [15:0] mem_dout, jump_target, data_addr;

    logic [15:0] a_mem_addr, a_pc, a_pc_plus1, a_instr, a_disp_ext;
    logic        a_halted, a_seq_err;
    logic [31:0] a_retired;

    logic [7:0]  b_mem_addr, b_pc;
    logic [15:0] b_pc_plus1, b_instr, b_disp_ext;
    logic        b_halted, b_seq_err;
    logic [1:0]  b_retired;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    pc_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .i_pc_en(pc_en), .i_branch(branch), .i_jump(jump),
        .i_ir_load(ir_load), .i_addr_sel(addr_sel), .i_mem_dout(mem_dout),
        .i_jump_target(jump_target), .i_data_addr(data_addr),
        .o_mem_addr(a_mem_addr), .o_pc(a_pc), .o_pc_plus1(a_pc_plus1), .o_instr(a_instr),
        .o_disp_ext(a_disp_ext), .o_halted(a_halted), .o_seq_err(a_seq_err),
        .o_retired(a_retired)
    );

    pc_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h10), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .i_pc_en(pc_en), .i_branch(branch), .i_jump(jump),
        .i_ir_load(ir_load), .i_addr_sel(addr_sel), .i_mem_dout(mem_dout),
        .i_jump_target(jump_target), .i_data_addr(data_addr),
        .o_mem_addr(b_mem_addr), .o_pc(b_pc), .o_pc_plus1(b_pc_plus1), .o_instr(b_instr),
        .o_disp_ext(b_disp_ext), .o_halted(b_halted), .o_seq_err(b_seq_err),
        .o_retired(b_retired)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 is the 16-bit build, index 1 the 8-bit build.
    longint m_mask  [2] = '{64'hFFFF, 64'hFF};
    longint m_rpc   [2] = '{64'h0000, 64'h10};
    longint m_rmax  [2] = '{64'hFFFF_FFFF, 64'h3};
    longint m_pc    [2];
    longint m_ret   [2];
    bit     m_halt  [2];
    bit     m_seq;
    longint m_instr;

    function automatic longint sext8(input longint v);
        longint b = v & 255;
        return (b >= 128) ? (b - 256) : b;
    endfunction

    always @(posedge clk) begin
        longint np;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = m_rpc[k]; m_halt[k] = 0; m_ret[k] = 0;
            end else if (pc_en) begin
                if (jump)        np = jump_target & m_mask[k];
                else if (branch) np = (m_pc[k] + sext8(m_instr)) & m_mask[k];
                else             np = (m_pc[k] + 1) & m_mask[k];
                if (branch && !jump && (m_instr & 255) == 0) m_halt[k] = 1;
                else if (np != m_pc[k])                      m_halt[k] = 0;
                if (m_ret[k] < m_rmax[k]) m_ret[k] = m_ret[k] + 1;
                m_pc[k] = np;
            end
        end
        if (rst) begin
            m_seq = 0; m_instr = 0;
        end else begin
            if (pc_en && branch && jump) m_seq = 1;
            if (ir_load) m_instr = mem_dout;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_pc",       64'(a_pc),       64'(m_pc[0]));
            chk("a_mem_addr", 64'(a_mem_addr), addr_sel ? 64'(m_pc[0]) : 64'(data_addr));
            chk("a_pc_plus1", 64'(a_pc_plus1), 64'((m_pc[0] + 1) & m_mask[0]));
            chk("a_instr",    64'(a_instr),    64'(m_instr));
            chk("a_disp_ext", 64'(a_disp_ext), 64'(sext8(m_instr) & 64'hFFFF));
            chk("a_halted",   64'(a_halted),   64'(m_halt[0]));
            chk("a_seq_err",  64'(a_seq_err),  64'(m_seq));
            chk("a_retired",  64'(a_retired),  64'(m_ret[0]));
            chk("b_pc",       64'(b_pc),       64'(m_pc[1]));
            chk("b_mem_addr", 64'(b_mem_addr), addr_sel ? 64'(m_pc[1]) : 64'(data_addr & 16'h00FF));
            chk("b_pc_plus1", 64'(b_pc_plus1), 64'((m_pc[1] + 1) & m_mask[1]));
            chk("b_instr",    64'(b_instr),    64'(m_instr));
            chk("b_halted",   64'(b_halted),   64'(m_halt[1]));
            chk("b_seq_err",  64'(b_seq_err),  64'(m_seq));
            chk("b_retired",  64'(b_retired),  64'(m_ret[1]));
        end
    end

    task automatic tick(input bit pe, input bit br, input bit jp, input bit irl,
                        input logic [15:0] dout);
        pc_en = pe; branch = br; jump = jp; ir_load = irl; mem_dout = dout;
        @(posedge clk);
        #1;
        pc_en = 0; branch = 0; jump = 0; ir_load = 0;
    endtask

    initial begin
        rst = 1; pc_en = 0; branch = 0; jump = 0; ir_load = 0; addr_sel = 1;
        mem_dout = 16'h0; jump_target = 16'h0; data_addr = 16'h0;
        tick(0, 0, 0, 0, 16'h0);
        rst = 0;
        cmp_en = 1;
        chk("reset_pc", 64'(a_pc), 64'h0);
        chk("reset_pc8", 64'(b_pc), 64'h10);
        chk("reset_instr", 64'(a_instr), 64'h0);
        chk("reset_pc_plus1", 64'(a_pc_plus1), 64'h1);

        // Strobes without pc_en are ignored.
        jump_target = 16'h0777;
        tick(0, 1, 1, 0, 16'h0);
        chk("no_pc_en_pc", 64'(a_pc), 64'h0);
        chk("no_pc_en_seq", 64'(a_seq_err), 64'h0);

        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 16'h0);
        chk("seq_pc", 64'(a_pc), 64'h3);
        chk("seq_retired", 64'(a_retired), 64'h3);
        chk("seq_pc_plus1", 64'(a_pc_plus1), 64'h4);

        // Negative branch displacement.
        tick(0, 0, 0, 1, 16'hC0FC);
        jump_target = 16'h0010;
        tick(1, 0, 1, 0, 16'h0);
        chk("disp_ext", 64'(a_disp_ext), 64'hFFFC);
        chk("retired_sat", 64'(b_retired), 64'h3);
        tick(1, 1, 0, 0, 16'h0);
        chk("branch_back", 64'(a_pc), 64'h000C);

        // Branch and jump together: jump wins, error is sticky.
        jump_target = 16'h1234;
        tick(1, 1, 1, 0, 16'h0);
        chk("jump_wins", 64'(a_pc), 64'h1234);
        chk("jump_wins8", 64'(b_pc), 64'h34);
        chk("seq_err_set", 64'(a_seq_err), 64'h1);
        tick(1, 0, 0, 0, 16'h0);
        chk("seq_err_sticky", 64'(a_seq_err), 64'h1);

        // Branch-to-self halt and its release.
        tick(0, 0, 0, 1, 16'hCE00);
        tick(1, 1, 0, 0, 16'h0);
        chk("halt_pc", 64'(a_pc), 64'h1235);
        chk("halt_set", 64'(a_halted), 64'h1);
        tick(0, 0, 0, 0, 16'h0);
        chk("halt_hold", 64'(a_halted), 64'h1);
        jump_target = 16'h0040;
        tick(1, 0, 1, 0, 16'h0);
        chk("halt_exit_pc", 64'(a_pc), 64'h0040);
        chk("halt_clear", 64'(a_halted), 64'h0);

        // Wrap at ADDR_W and branch with wrap, with ir_load alongside pc_en.
        jump_target = 16'h00FF;
        tick(1, 0, 1, 0, 16'h0);
        tick(1, 0, 0, 0, 16'h0);
        chk("wrap8", 64'(b_pc), 64'h00);
        chk("nowrap16", 64'(a_pc), 64'h0100);
        jump_target = 16'h0002;
        tick(1, 0, 1, 1, 16'h00F0);
        chk("irl_with_pc_en", 64'(a_instr), 64'h00F0);
        chk("jump_pc2", 64'(b_pc), 64'h02);
        tick(1, 1, 0, 0, 16'h0);
        chk("branch_wrap8", 64'(b_pc), 64'hF2);
        chk("branch_wrap16", 64'(a_pc), 64'hFFF2);

        // Data address path and instruction capture.
        addr_sel = 0; data_addr = 16'h0155;
        tick(0, 0, 0, 1, 16'hABCD);
        chk("ir_capture", 64'(a_instr), 64'hABCD);
        chk("data_mem_addr", 64'(a_mem_addr), 64'h0155);
        chk("data_mem_addr8", 64'(b_mem_addr), 64'h55);
        addr_sel = 1;
        #1;
        chk("pc_mem_addr", 64'(a_mem_addr), 64'hFFF2);

        // Reset during a strobe cycle discards the strobes.
        rst = 1;
        tick(1, 1, 1, 1, 16'h5555);
        rst = 0;
        chk("rst_mid_pc", 64'(a_pc), 64'h0);
        chk("rst_mid_pc8", 64'(b_pc), 64'h10);
        chk("rst_mid_seq", 64'(a_seq_err), 64'h0);
        chk("rst_mid_instr", 64'(a_instr), 64'h0);
        chk("rst_mid_retired", 64'(b_retired), 64'h0);
        tick(1, 0, 0, 0, 16'h0);
        chk("post_rst_pc", 64'(a_pc), 64'h1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
